// File: rtl/div_unit_pkg.sv
// Shared CPU constants: control-unit opcode/funct codes and the divider's FSM encoding.
// Also provides the magnitude helper used by the signed divider.
package div_unit_pkg;

   localparam int unsigned DIV_W     = 32;
   localparam int unsigned MAG_W     = 33;
   localparam int unsigned CNT_W     = 6;
   localparam int unsigned STATE_W   = 2;
   localparam int unsigned DIV_ITERS = 32;

   localparam logic [STATE_W-1:0] S_IDLE = 2'd0;
   localparam logic [STATE_W-1:0] S_ITER = 2'd1;
   localparam logic [STATE_W-1:0] S_FIX  = 2'd2;

   // Control-unit decode constants
   localparam logic [5:0] OP_RTYPE   = 6'h00;
   localparam logic [5:0] FUNCT_MFHI = 6'h10;
   localparam logic [5:0] FUNCT_MFLO = 6'h12;
   localparam logic [5:0] FUNCT_MULT = 6'h18;
   localparam logic [5:0] FUNCT_DIV  = 6'h1A;

   // 33-bit magnitude so that |0x80000000| is exact
   function automatic logic [MAG_W-1:0] abs_mag(input logic [DIV_W-1:0] v);
      logic [MAG_W-1:0] ext;
      ext = {v[DIV_W-1], v};
      return v[DIV_W-1] ? MAG_W'(-ext) : ext;
   endfunction

endpackage

// File: rtl/div_unit_if.sv
// Operand/result bus between the control unit / register file and the divider.
interface div_unit_if;
   import div_unit_pkg::*;

   logic             DivCtrl;
   logic [DIV_W-1:0] A;
   logic [DIV_W-1:0] B;
   logic [DIV_W-1:0] HI;
   logic [DIV_W-1:0] LO;
   logic             DivBusy;
   logic             DivDone;
   logic             DivZero;

   modport master (output DivCtrl, A, B,
                   input  HI, LO, DivBusy, DivDone, DivZero);

   modport slave  (input  DivCtrl, A, B,
                   output HI, LO, DivBusy, DivDone, DivZero);

endinterface

// File: rtl/div_unit.sv
// Signed 32-bit restoring divider, one quotient bit per cycle, 33 edges start-to-done.
// Optional macro DIV_ZERO_EXC_EN: B=0 raises a DivZero pulse instead of dividing.
module div_unit
   import div_unit_pkg::*;
(
   input logic       clock,
   input logic       reset,
   div_unit_if.slave bus
);

   logic [STATE_W-1:0] state_q, state_nxt;
   logic [CNT_W-1:0]   cnt_q, cnt_nxt;
   logic               a_neg_q, a_neg_nxt;
   logic               b_neg_q, b_neg_nxt;
   logic [MAG_W-1:0]   b_mag_q, b_mag_nxt;
   logic [MAG_W-1:0]   dvd_q, dvd_nxt;
   logic [MAG_W-1:0]   rem_q, rem_nxt;
   logic [DIV_W-1:0]   hi_q, hi_nxt;
   logic [DIV_W-1:0]   lo_q, lo_nxt;
   logic               busy_q, busy_nxt;
   logic               done_q, done_nxt;
   logic               zero_nxt;
   logic               start_c;
   logic [MAG_W:0]     shifted_c;
   logic [MAG_W+1:0]   diff_c;
   logic               borrow_c;

   // Start qualification; a zero divisor becomes an exception when enabled
`ifdef DIV_ZERO_EXC_EN
   logic zero_q;
   always_comb begin
      start_c  = bus.DivCtrl && (bus.B != '0);
      zero_nxt = (state_q == S_IDLE) && bus.DivCtrl && (bus.B == '0);
   end
`else
   always_comb begin
      start_c  = bus.DivCtrl;
      zero_nxt = 1'b0;
   end
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         a_neg_q <= 1'b0;
         b_neg_q <= 1'b0;
         b_mag_q <= '0;
         dvd_q   <= '0;
         rem_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef DIV_ZERO_EXC_EN
         zero_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_nxt;
         cnt_q   <= cnt_nxt;
         a_neg_q <= a_neg_nxt;
         b_neg_q <= b_neg_nxt;
         b_mag_q <= b_mag_nxt;
         dvd_q   <= dvd_nxt;
         rem_q   <= rem_nxt;
         hi_q    <= hi_nxt;
         lo_q    <= lo_nxt;
         busy_q  <= busy_nxt;
         done_q  <= done_nxt;
`ifdef DIV_ZERO_EXC_EN
         zero_q  <= zero_nxt;
`endif
      end
   end

   // Next state plus the inline restoring step (shift in next dividend bit, trial subtract)
   always_comb begin
      state_nxt = state_q;
      cnt_nxt   = cnt_q;
      a_neg_nxt = a_neg_q;
      b_neg_nxt = b_neg_q;
      b_mag_nxt = b_mag_q;
      dvd_nxt   = dvd_q;
      rem_nxt   = rem_q;
      hi_nxt    = hi_q;
      lo_nxt    = lo_q;
      busy_nxt  = busy_q;
      done_nxt  = 1'b0;

      shifted_c = {rem_q, dvd_q[DIV_W-1]};
      diff_c    = {1'b0, shifted_c} - {2'b00, b_mag_q};
      borrow_c  = diff_c[MAG_W+1];

      case (state_q)
         S_IDLE: begin
            if (start_c) begin
               a_neg_nxt = bus.A[DIV_W-1];
               b_neg_nxt = bus.B[DIV_W-1];
               dvd_nxt   = abs_mag(bus.A);
               b_mag_nxt = abs_mag(bus.B);
               rem_nxt   = '0;
               cnt_nxt   = '0;
               busy_nxt  = 1'b1;
               state_nxt = S_ITER;
            end
         end
         S_ITER: begin
            rem_nxt = borrow_c ? MAG_W'(shifted_c) : MAG_W'(diff_c);
            dvd_nxt = {dvd_q[DIV_W-1:0], ~borrow_c};
            cnt_nxt = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DIV_ITERS - 1)) begin
               state_nxt = S_FIX;
            end
         end
         S_FIX: begin
            lo_nxt    = DIV_W'((a_neg_q ^ b_neg_q) ? -dvd_q : dvd_q);
            hi_nxt    = DIV_W'(a_neg_q ? -rem_q : rem_q);
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
            state_nxt = S_IDLE;
         end
         default: begin
            busy_nxt  = 1'b0;
            state_nxt = S_IDLE;
         end
      endcase
   end

   assign bus.HI      = hi_q;
   assign bus.LO      = lo_q;
   assign bus.DivBusy = busy_q;
   assign bus.DivDone = done_q;
`ifdef DIV_ZERO_EXC_EN
   assign bus.DivZero = zero_q;
`else
   assign bus.DivZero = 1'b0;
`endif

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit; both DIV_ZERO_EXC_EN builds are covered.
module tb_div_unit;

   logic clock;
   logic reset;
   int   n_cmp;
   int   n_err;

   div_unit_if bus ();

   div_unit dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Issue one start pulse and watch up to 40 edges for DivDone
   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int busy_n,
                         output bit stable, output int zero_n);
      logic [31:0] hi0, lo0;
      @(negedge clock);
      bus.A = a; bus.B = b; bus.DivCtrl = 1'b1;
      hi0 = bus.HI; lo0 = bus.LO;
      @(posedge clock); #1;
      bus.DivCtrl = 1'b0;
      lat = -1; stable = 1'b1;
      busy_n = bus.DivBusy ? 1 : 0;
      zero_n = bus.DivZero ? 1 : 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clock); #1;
         if (bus.DivZero) zero_n++;
         if (bus.DivDone) begin
            lat = k;
            break;
         end
         if (bus.DivBusy) busy_n++;
         if (bus.HI !== hi0 || bus.LO !== lo0) stable = 1'b0;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.DivCtrl = 1'b0; bus.A = '0; bus.B = '0;
      #3 reset = 1'b0;
      #1;
      n_cmp++; if (bus.HI !== 32'h0) begin n_err++; $display("FAIL reset_hi: got %h want %h", bus.HI, 32'h0); end
      n_cmp++; if (bus.LO !== 32'h0) begin n_err++; $display("FAIL reset_lo: got %h want %h", bus.LO, 32'h0); end
      n_cmp++; if ({bus.DivBusy, bus.DivDone, bus.DivZero} !== 3'b000) begin
         n_err++; $display("FAIL reset_flags: got %b want 000", {bus.DivBusy, bus.DivDone, bus.DivZero}); end
      repeat (2) @(posedge clock);
      @(negedge clock); reset = 1'b1;
   endtask

   task automatic test_basic();
      int lat, busy_n, zero_n; bit stable;
      run_op(32'd100, 32'd7, lat, busy_n, stable, zero_n);
      n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL basic_latency: got %0d want 33", lat); end
      n_cmp++; if (busy_n !== 33) begin n_err++; $display("FAIL basic_busy_cycles: got %0d want 33", busy_n); end
      n_cmp++; if (bus.LO !== 32'h0000000E) begin n_err++; $display("FAIL basic_lo: got %h want %h", bus.LO, 32'h0000000E); end
      n_cmp++; if (bus.HI !== 32'h00000002) begin n_err++; $display("FAIL basic_hi: got %h want %h", bus.HI, 32'h00000002); end
      n_cmp++; if (stable !== 1'b1) begin n_err++; $display("FAIL basic_hilo_hold: got %b want 1", stable); end
      @(posedge clock); #1;
      n_cmp++; if ({bus.DivDone, bus.DivBusy} !== 2'b00) begin
         n_err++; $display("FAIL basic_done_pulse: got %b want 00", {bus.DivDone, bus.DivBusy}); end
   endtask

   task automatic test_signed();
      int lat, busy_n, zero_n; bit stable;
      run_op(32'hFFFFFF9C, 32'd7, lat, busy_n, stable, zero_n);
      n_cmp++; if (bus.LO !== 32'hFFFFFFF2) begin n_err++; $display("FAIL negdvd_lo: got %h want %h", bus.LO, 32'hFFFFFFF2); end
      n_cmp++; if (bus.HI !== 32'hFFFFFFFE) begin n_err++; $display("FAIL negdvd_hi: got %h want %h", bus.HI, 32'hFFFFFFFE); end
      n_cmp++; if (stable !== 1'b1) begin n_err++; $display("FAIL negdvd_hilo_hold: got %b want 1", stable); end
      run_op(32'd100, 32'hFFFFFFF9, lat, busy_n, stable, zero_n);
      n_cmp++; if (bus.LO !== 32'hFFFFFFF2) begin n_err++; $display("FAIL negdvs_lo: got %h want %h", bus.LO, 32'hFFFFFFF2); end
      n_cmp++; if (bus.HI !== 32'h00000002) begin n_err++; $display("FAIL negdvs_hi: got %h want %h", bus.HI, 32'h00000002); end
   endtask

   task automatic test_overflow();
      int lat, busy_n, zero_n; bit stable;
      run_op(32'h80000000, 32'hFFFFFFFF, lat, busy_n, stable, zero_n);
      n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL ovf_latency: got %0d want 33", lat); end
      n_cmp++; if (bus.LO !== 32'h80000000) begin n_err++; $display("FAIL ovf_lo: got %h want %h", bus.LO, 32'h80000000); end
      n_cmp++; if (bus.HI !== 32'h00000000) begin n_err++; $display("FAIL ovf_hi: got %h want %h", bus.HI, 32'h0); end
      n_cmp++; if (zero_n !== 0) begin n_err++; $display("FAIL ovf_divzero: got %0d pulses want 0", zero_n); end
   endtask

   task automatic test_div_zero();
      int lat, busy_n, zero_n; bit stable;
      run_op(32'd5, 32'd0, lat, busy_n, stable, zero_n);
`ifdef DIV_ZERO_EXC_EN
      n_cmp++; if (zero_n !== 1) begin n_err++; $display("FAIL dz_pulses: got %0d want 1", zero_n); end
      n_cmp++; if (busy_n !== 0) begin n_err++; $display("FAIL dz_busy: got %0d want 0", busy_n); end
      n_cmp++; if (lat !== -1) begin n_err++; $display("FAIL dz_no_done: got %0d want -1", lat); end
      n_cmp++; if (stable !== 1'b1) begin n_err++; $display("FAIL dz_hilo_hold: got %b want 1", stable); end
      n_cmp++; if (bus.LO !== 32'h80000000) begin n_err++; $display("FAIL dz_lo: got %h want %h", bus.LO, 32'h80000000); end
`else
      n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL dz_latency: got %0d want 33", lat); end
      n_cmp++; if (zero_n !== 0) begin n_err++; $display("FAIL dz_pulses: got %0d want 0", zero_n); end
      n_cmp++; if (bus.LO !== 32'hFFFFFFFF) begin n_err++; $display("FAIL dz_lo: got %h want %h", bus.LO, 32'hFFFFFFFF); end
      n_cmp++; if (bus.HI !== 32'h00000005) begin n_err++; $display("FAIL dz_hi: got %h want %h", bus.HI, 32'h5); end
`endif
   endtask

   task automatic test_reset_abort();
      int lat, busy_n, zero_n, dones; bit stable;
      @(negedge clock);
      bus.A = 32'd100; bus.B = 32'd7; bus.DivCtrl = 1'b1;
      @(posedge clock); #1;
      bus.DivCtrl = 1'b0;
      repeat (9) @(posedge clock);
      @(posedge clock); #1;
      reset = 1'b0;
      #1;
      n_cmp++; if ({bus.HI, bus.LO} !== 64'h0) begin n_err++; $display("FAIL abort_hilo: got %h want 0", {bus.HI, bus.LO}); end
      n_cmp++; if ({bus.DivBusy, bus.DivDone, bus.DivZero} !== 3'b000) begin
         n_err++; $display("FAIL abort_flags: got %b want 000", {bus.DivBusy, bus.DivDone, bus.DivZero}); end
      repeat (2) @(posedge clock);
      @(negedge clock); reset = 1'b1;
      dones = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clock); #1;
         if (bus.DivDone || bus.DivBusy) dones++;
      end
      n_cmp++; if (dones !== 0) begin n_err++; $display("FAIL abort_no_done: got %0d active cycles want 0", dones); end
      run_op(32'd9, 32'd2, lat, busy_n, stable, zero_n);
      n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL post_reset_latency: got %0d want 33", lat); end
      n_cmp++; if (bus.LO !== 32'd4) begin n_err++; $display("FAIL post_reset_lo: got %h want %h", bus.LO, 32'd4); end
      n_cmp++; if (bus.HI !== 32'd1) begin n_err++; $display("FAIL post_reset_hi: got %h want %h", bus.HI, 32'd1); end
   endtask

   task automatic test_ignore_start();
      int dones, done_k;
      @(negedge clock);
      bus.A = 32'd100; bus.B = 32'd7; bus.DivCtrl = 1'b1;
      @(posedge clock); #1;
      dones = 0; done_k = -1;
      for (int k = 1; k <= 45; k++) begin
         @(negedge clock);
         bus.A = 32'd1; bus.B = 32'd1;
         bus.DivCtrl = (k == 5 || k == 33);
         @(posedge clock); #1;
         if (bus.DivDone) begin dones++; done_k = k; end
      end
      bus.DivCtrl = 1'b0;
      n_cmp++; if (dones !== 1) begin n_err++; $display("FAIL ign_done_count: got %0d want 1", dones); end
      n_cmp++; if (done_k !== 33) begin n_err++; $display("FAIL ign_done_edge: got %0d want 33", done_k); end
      n_cmp++; if (bus.LO !== 32'd14) begin n_err++; $display("FAIL ign_lo: got %h want %h", bus.LO, 32'd14); end
      n_cmp++; if (bus.HI !== 32'd2) begin n_err++; $display("FAIL ign_hi: got %h want %h", bus.HI, 32'd2); end
      n_cmp++; if (bus.DivBusy !== 1'b0) begin n_err++; $display("FAIL ign_idle: got %b want 0", bus.DivBusy); end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      test_reset();
      test_basic();
      test_signed();
      test_overflow();
      test_div_zero();
      test_reset_abort();
      test_ignore_start();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 clock  in  1  single clock; all state updates on posedge clock.
REQ-002 reset  in  1  asynchronous, active-low reset; asserting it low resets the block immediately, independent of clock.
REQ-003 DivCtrl  in  1  start request from the control unit; sampled on posedge clock.
REQ-004 A  in  32  dividend (register A output); two's complement.
REQ-005 B  in  32  divisor (register B output); two's complement.
REQ-006 HI  out  32  remainder register; consumed by the HI write path.
REQ-007 LO  out  32  quotient register; consumed by the LO write path.
REQ-008 DivBusy  out  1  high while a division is in progress.
REQ-009 DivDone  out  1  one-cycle pulse when HI/LO hold a new result.
REQ-010 DivZero  out  1  one-cycle pulse on divide-by-zero; routed to exception logic.

Function
REQ-011 The block SHALL implement signed 32-bit division: quotient truncates toward zero, and the remainder takes the sign of the dividend.
REQ-012 The FSM SHALL have states IDLE, ITER and FIX, and encode them in 2 bits.
REQ-013 In IDLE, when DivCtrl=1 at edge t, the block SHALL:
- latch |A| and |B| and both sign bits;
- clear the partial remainder and the 6-bit counter;
- set DivBusy=1 and go to ITER.
REQ-014 In ITER, each edge SHALL perform one restoring shift-subtract step, producing one quotient bit MSB-first. After 32 steps (edges t+1..t+32) the FSM SHALL go to FIX.
REQ-015 In FIX (edge t+33), the block SHALL:
- negate the quotient if the sign bits differ, and negate the remainder if A was negative;
- write LO=quotient and HI=remainder;
- pulse DivDone=1 for exactly one cycle, clear DivBusy, and return to IDLE.
REQ-016 Latency SHALL be 33 edges from DivCtrl sample to DivDone.
REQ-017 HI and LO SHALL change only at the FIX edge; at all other times they hold their previous values.
REQ-018 DivCtrl while DivBusy=1 SHALL be ignored; the operands in flight are unaffected.
REQ-019 DivCtrl at the same edge as FIX SHALL be ignored; a new operation is accepted only from IDLE on a later edge.
REQ-020 A=0x80000000, B=0xFFFFFFFF SHALL yield LO=0x80000000, HI=0, with no exception.
REQ-021 Internal magnitude registers SHALL be 33 bits wide so that |0x80000000| is represented exactly.

Reset
REQ-022 While reset=0, the block SHALL force: HI=0, LO=0, DivBusy=0, DivDone=0, DivZero=0, counter=0, state=IDLE.
REQ-023 Reset asserted mid-operation SHALL abort the division with no DivDone. The first DivCtrl after reset release SHALL be accepted normally.

Configuration
REQ-024 Macro DIV_ZERO_EXC_EN, when defined:
- B=0 at the start edge SHALL pulse DivZero for one cycle;
- DivBusy SHALL remain 0 and no iteration is performed;
- HI and LO SHALL remain unchanged.
REQ-025 Without DIV_ZERO_EXC_EN:
- DivZero SHALL be tied to 0;
- B=0 SHALL run the normal 33-edge sequence, giving quotient magnitude 0xFFFFFFFF and remainder |A| before sign fix (e.g. A=7 gives LO=0xFFFFFFFF, HI=7).

Structure
REQ-026 The state encoding constants and DIV_ITERS=32 SHALL live in the shared CPU package, alongside the control-unit opcode/funct constants.
REQ-027 The block SHALL be a single module with no sub-module; the restoring step is inline combinational logic feeding the iteration registers.

Verification
REQ-028 A=100, B=7, DivCtrl pulse -> LO=0x0000000E, HI=0x00000002, DivDone exactly 33 edges after start, DivBusy high for 33 cycles.
REQ-029 A=-100 (0xFFFFFF9C), B=7 -> LO=0xFFFFFFF2, HI=0xFFFFFFFE; then A=100, B=-7 -> LO=0xFFFFFFF2, HI=0x00000002.
REQ-030 A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0x00000000, DivZero=0.
REQ-031 With DIV_ZERO_EXC_EN, A=5, B=0 -> DivZero high for one cycle, DivBusy never high, HI/LO keep prior values; without the macro -> LO=0xFFFFFFFF, HI=5 after 33 edges.
REQ-032 Start 100/7, pulse reset low at edge t+10 -> all outputs 0 immediately, no DivDone. After release, start 9/2 -> LO=4, HI=1.
REQ-033 Start 100/7, re-pulse DivCtrl with A=1, B=1 at edge t+5 and again at the FIX edge -> single DivDone, LO=14, HI=2, block returns to IDLE.
